// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------------------------------------------------------------------
// Sits between the execute stage and the data RAM. It turns RISC-V
// LB/LH/LW/LBU/LHU/SB/SH/SW requests into the RAM's one-hot write-enable and
// registered-read protocol. Load data is sign- or zero-extended here. The unit
// handles one request at a time.
//
// Parameters
//   MEM_BYTES        : RAM size in bytes. Any address >= MEM_BYTES faults.
//
// Ports
//   clk, rst         : clock and synchronous active-high reset
//   req_valid/ready  : request handshake. Ready is high only in IDLE with
//                      rst low.
//   req_we           : 1 = store, 0 = load
//   req_funct3       : access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr         : byte address
//   req_wdata        : store data, low-aligned
//   resp_valid       : one-cycle completion pulse
//   resp_rdata       : extended load data (0 for stores and faults)
//   resp_fault       : illegal, out-of-range or (optionally) misaligned access
//   mem_write_enable : one-hot to RAM (001 word, 010 half, 100 byte)
//   mem_addr         : address to RAM
//   mem_data_in      : write data to RAM, masked to the access width
//   mem_data_out     : registered read data from RAM, already shifted right
//                      by addr[1:0]
//
// Build option
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned H/W accesses fault.
//                          When undefined, the address is silently aligned
//                          down.
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [2:0]  mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] MEM_LIMIT = MEM_BYTES;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Request fields kept for the later stages of the access.
  logic       we_p0;
  logic [2:0] funct3_p0;

  logic        accept;
  logic        funct3_ok;
  logic        store_illegal;
  logic        range_bad;
  logic        fault_now;
  logic [2:0]  size_code;
  logic [31:0] addr_eff;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  // Keep only the bytes that the write enable covers. Upper bits are 0.
  function automatic logic [31:0] mask_wdata(input logic [2:0] we,
                                             input logic [31:0] d);
    logic [31:0] r;
    case (we)
      WE_BYTE: r = {24'd0, d[7:0]};
      WE_HALF: r = {16'd0, d[15:0]};
      WE_WORD: r = d;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Sign- or zero-extend the RAM data. The RAM has already shifted the
  // addressed byte down to bit 0.
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b100:  r = {24'd0, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request decode. This logic drives only registers, so no req_* input
  // reaches an output combinationally.
  always_comb begin
    size_code = WE_NONE;
    funct3_ok = 1'b1;
    case (req_funct3)
      3'b000, 3'b100: size_code = WE_BYTE;
      3'b001, 3'b101: size_code = WE_HALF;
      3'b010:         size_code = WE_WORD;
      default:        funct3_ok = 1'b0;
    endcase

    // funct3 values 110 and 111 are already rejected above. The only
    // remaining illegal stores are the unsigned forms 100 and 101.
    store_illegal = req_we && req_funct3[2];
    range_bad     = (req_addr >= MEM_LIMIT);

    addr_eff = req_addr;
    if (size_code == WE_HALF) addr_eff[0]   = 1'b0;
    if (size_code == WE_WORD) addr_eff[1:0] = 2'b00;

`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((size_code == WE_HALF) && req_addr[0]) ||
                 ((size_code == WE_WORD) && (req_addr[1:0] != 2'b00));
    fault_now  = !funct3_ok || store_illegal || range_bad || misaligned;
`else
    fault_now  = !funct3_ok || store_illegal || range_bad;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = fault_now ? S_RESP : S_ACCESS;
      S_ACCESS:  state_d = we_p0 ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register. Ready is also gated by rst, so
  // no request is accepted at an edge where reset is applied.
  always_comb begin
    req_ready  = (state_q == S_IDLE) && !rst;
    resp_valid = (state_q == S_RESP);
  end

  assign accept = req_valid && req_ready;

  // ---- stage p0: acceptance edge latches the request and drives the RAM ----
  // The RAM samples mem_write_enable at the edge that ends ACCESS. That edge
  // still writes even if it is also a reset edge, because the enable is
  // cleared only afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p0            <= 1'b0;
      funct3_p0        <= 3'b000;
      resp_fault       <= 1'b0;
      resp_rdata       <= 32'd0;
      mem_write_enable <= WE_NONE;
      mem_addr         <= 32'd0;
      mem_data_in      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_p0      <= req_we;
            funct3_p0  <= req_funct3;
            resp_fault <= fault_now;
            resp_rdata <= 32'd0;
            if (!fault_now) begin
              mem_addr <= addr_eff;
              if (req_we) begin
                mem_write_enable <= size_code;
                mem_data_in      <= mask_wdata(size_code, req_wdata);
              end
            end
          end
        end
        // ---- stage p1: ACCESS, the RAM writes or registers its read ----
        S_ACCESS: mem_write_enable <= WE_NONE;
        // ---- stage p2: CAPTURE, extend the registered RAM data ----
        S_CAPTURE: resp_rdata <= extend_load(funct3_p0, mem_data_out);
        S_RESP:    resp_fault <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [2:0]  mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int resp_cnt = 0;
  int wr_cnt   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Byte-wide RAM model. The read is registered and shifted right by addr[1:0].
  logic [7:0] ram [0:4095];
  initial for (int i = 0; i < 4096; i++) ram[i] = 8'h00;

  always @(posedge clk) begin
    logic [11:0] a;
    logic [11:0] w;
    logic [31:0] word;
    a = mem_addr[11:0];
    w = {a[11:2], 2'b00};
    word = {ram[w+3], ram[w+2], ram[w+1], ram[w]};
    mem_data_out <= word >> (8 * a[1:0]);
    case (mem_write_enable)
      3'b001: begin
        ram[w]   <= mem_data_in[7:0];
        ram[w+1] <= mem_data_in[15:8];
        ram[w+2] <= mem_data_in[23:16];
        ram[w+3] <= mem_data_in[31:24];
        wr_cnt   <= wr_cnt + 1;
      end
      3'b010: begin
        ram[{a[11:1], 1'b0}]   <= mem_data_in[7:0];
        ram[{a[11:1], 1'b1}]   <= mem_data_in[15:8];
        wr_cnt <= wr_cnt + 1;
      end
      3'b100: begin
        ram[a] <= mem_data_in[7:0];
        wr_cnt <= wr_cnt + 1;
      end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected no response", cycle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, " rdata"}, resp_rdata, e.rdata);
        chk({e.nm, " fault"}, 32'(resp_fault), 32'(e.fault));
        chk({e.nm, " latency"}, 32'(cycle - e.acc), 32'(e.lat));
      end
    end
  end

  // Issue one request. The task queues the expected response and checks the
  // RAM-side signals right after the acceptance edge and one edge later.
  task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_fault,
                        input int exp_lat, input logic [2:0] exp_mwe,
                        input logic [31:0] exp_maddr, input logic [31:0] exp_din);
    logic rdy;
    bit   ok;
    int   w0;
    exp_t e;
    ok = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin ok = 1; break; end
      #1;
    end
    #1;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s accept: got no acceptance expected acceptance within 20 cycles", nm);
      req_valid = 1'b0;
      return;
    end
    e.nm = nm; e.rdata = exp_rdata; e.fault = exp_fault; e.lat = exp_lat; e.acc = cycle;
    exp_q.push_back(e);
    req_valid = 1'b0;
    chk({nm, " ready_busy"}, 32'(req_ready), 32'd0);
    chk({nm, " mwe_e0"}, 32'(mem_write_enable), 32'(exp_mwe));
    if (!exp_fault) chk({nm, " mem_addr"}, mem_addr, exp_maddr);
    if (exp_mwe != 3'b000) chk({nm, " mem_data_in"}, mem_data_in, exp_din);
    @(posedge clk); #1;
    chk({nm, " mwe_e1"}, 32'(mem_write_enable), 32'd0);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s resp: got no resp_valid expected one within 10 cycles", nm);
      exp_q.delete();
    end
    chk({nm, " writes"}, 32'(wr_cnt - w0), (exp_mwe != 3'b000) ? 32'd1 : 32'd0);
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [31:0] W100 = 32'hDEADBEEF;
`else
  localparam logic [31:0] W100 = 32'hCAFEBEEF;
`endif

  initial begin
    int r0;
    // A request held during reset must never be accepted.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h55;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_fault", 32'(resp_fault), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mwe", 32'(mem_write_enable), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_data_in", mem_data_in, 32'd0);
    rst = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst writes", 32'(wr_cnt), 32'd0);
    chk("post_rst resps", 32'(resp_cnt), 32'd0);
    chk("post_rst ready", 32'(req_ready), 32'd1);

    //      name        we    f3      addr      wdata         rdata         flt lat mwe     maddr     din
    do_req("SW100",   1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 3'b001, 32'h100, 32'hDEADBEEF);
    do_req("LW100",   1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 2, 3'b000, 32'h100, 32'h0);
    do_req("LB103",   1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFDE, 0, 2, 3'b000, 32'h103, 32'h0);
    do_req("LBU103",  1'b0, 3'b100, 32'h103, 32'h0,        32'h000000DE, 0, 2, 3'b000, 32'h103, 32'h0);
    do_req("LH102",   1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFDEAD, 0, 2, 3'b000, 32'h102, 32'h0);
    do_req("LHU102",  1'b0, 3'b101, 32'h102, 32'h0,        32'h0000DEAD, 0, 2, 3'b000, 32'h102, 32'h0);
    do_req("LB100",   1'b0, 3'b000, 32'h100, 32'h0,        32'hFFFFFFEF, 0, 2, 3'b000, 32'h100, 32'h0);
    do_req("SB_A0",   1'b1, 3'b000, 32'hA0,  32'h1234565A, 32'h0,        0, 1, 3'b100, 32'hA0,  32'h5A);
    do_req("LBU_A0",  1'b0, 3'b100, 32'hA0,  32'h0,        32'h0000005A, 0, 2, 3'b000, 32'hA0,  32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("LW101",   1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 0, 3'b000, 32'h0,   32'h0);
    do_req("SH103",   1'b1, 3'b001, 32'h103, 32'h1234CAFE, 32'h0,        1, 0, 3'b000, 32'h0,   32'h0);
`else
    do_req("LW101",   1'b0, 3'b010, 32'h101, 32'h0,        32'hDEADBEEF, 0, 2, 3'b000, 32'h100, 32'h0);
    do_req("SH103",   1'b1, 3'b001, 32'h103, 32'h1234CAFE, 32'h0,        0, 1, 3'b010, 32'h102, 32'h0000CAFE);
`endif
    do_req("LW100b",  1'b0, 3'b010, 32'h100, 32'h0,        W100,         0, 2, 3'b000, 32'h100, 32'h0);
    do_req("LW1000",  1'b0, 3'b010, 32'h1000,32'h0,        32'h0,        1, 0, 3'b000, 32'h0,   32'h0);
    do_req("F3_011",  1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 0, 3'b000, 32'h0,   32'h0);
    do_req("ST_F3_4", 1'b1, 3'b100, 32'h104, 32'hFFFFFFFF, 32'h0,        1, 0, 3'b000, 32'h0,   32'h0);
    do_req("SW_OOR",  1'b1, 3'b010, 32'h2000,32'hFFFFFFFF, 32'h0,        1, 0, 3'b000, 32'h0,   32'h0);
    do_req("LW104",   1'b0, 3'b010, 32'h104, 32'h0,        32'h0,        0, 2, 3'b000, 32'h104, 32'h0);

    // Reset during CAPTURE of a load drops the response.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    chk("rstcap ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;               // E0 accepted, ACCESS
    r0 = resp_cnt;
    req_valid = 1'b0;
    @(posedge clk);                   // E1, CAPTURE
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rstcap ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;               // E2 sampled with rst high
    chk("rstcap resp_valid", 32'(resp_valid), 32'd0);
    chk("rstcap mwe", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstcap no_resp", 32'(resp_cnt - r0), 32'd0);
    chk("rstcap ready_back", 32'(req_ready), 32'd1);
    do_req("LW_after", 1'b0, 3'b010, 32'h100, 32'h0, W100, 0, 2, 3'b000, 32'h100, 32'h0);

    repeat (3) @(negedge clk);
    chk("final queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU core's execute stage and the data `ram`, translating RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into the RAM's one-hot write-enable and registered-read protocol. Loads get byte/halfword extraction and sign or zero extension. Misaligned, out-of-range and illegal requests are flagged as faults. One request is in flight at a time, with a valid/ready request handshake and a one-cycle response pulse.

## Interface
- `MEM_BYTES`, default 4096: RAM size in bytes. Any access with `addr >= MEM_BYTES` faults.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request. High only in IDLE; low while `rst` is high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low-aligned.
- `resp_valid` out 1: one-cycle completion pulse for every accepted request.
- `resp_rdata` out 32: extended load data. 0 for stores and faults.
- `resp_fault` out 1: qualified by `resp_valid`.
- `mem_write_enable` out 3: to RAM. 001 word, 010 half, 100 byte. Never more than one bit set.
- `mem_addr` out 32: to RAM.
- `mem_data_in` out 32: to RAM.
- `mem_data_out` in 32: from RAM. Registered, and already right-shifted by `addr[1:0]`.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- Acceptance: at a rising edge where `req_valid && req_ready`. The unit latches `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- Fault check at acceptance. Any of the following goes straight to RESP with `resp_fault=1` and no RAM access:
  - funct3 ∉ {000, 001, 010, 100, 101};
  - store with funct3 100 or 101;
  - `req_addr >= MEM_BYTES`;
  - a misaligned access, when enabled (see Configuration).
- Otherwise IDLE → ACCESS.
- ACCESS (one cycle):
  - `mem_addr` = latched address.
  - Store: `mem_write_enable` = size code. `mem_data_in` = `req_wdata` masked to the access width (upper bits 0). Next state RESP.
  - Load: `mem_write_enable=000`. Next state CAPTURE.
- CAPTURE: sample `mem_data_out` and form the result. Next state RESP.
  - LB: sign-extend `[7:0]`.
  - LBU: zero-extend `[7:0]`.
  - LH: sign-extend `[15:0]`.
  - LHU: zero-extend `[15:0]`.
  - LW: all 32 bits.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- `mem_addr` holds the latched address from ACCESS through RESP. In IDLE it holds its last value.
- `req_ready` is low in ACCESS, CAPTURE and RESP. Requests presented then are not accepted and must be held by the requester.
- Address 0xA0 byte store (GPIO) is an ordinary SB. The unit gives it no special treatment.

## Timing
- Edge numbering: acceptance edge is E0; each later rising edge is E1, E2, …
- Store: `mem_write_enable` is high E0–E1, and the RAM writes at E1. `resp_valid` is high E1–E2. Throughput is 1 request per 3 cycles (including the IDLE cycle).
- Load: ACCESS is E0–E1, the RAM registers its output at E1, and `resp_rdata` is captured at E2. `resp_valid` is high E2–E3.
- Fault: `resp_valid` and `resp_fault` are high E0–E1. `mem_write_enable` stays 000 throughout.
- All outputs are registered or decoded from the state register only. There is no combinational path from `req_*` to `mem_*` or `resp_*`.
- Reset values: state IDLE; `resp_valid`, `resp_fault` and `resp_rdata` = 0; `mem_write_enable` = 000; `mem_addr` and `mem_data_in` = 0; `req_ready` = 0 while `rst` is asserted.
- Reset mid-operation:
  - The in-flight request is dropped and no `resp_valid` is issued.
  - If `rst` is sampled at the edge ending ACCESS of a store, that RAM write still occurs. `mem_write_enable` is 000 from the next cycle on.
- `rst` and `req_valid` asserted together: reset wins and nothing is accepted.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- Defined: these accesses fault with no RAM access:
  - H/HU/SH with `addr[0]=1`;
  - W/SW with `addr[1:0]≠0`.
- Undefined: the address is silently aligned down (`addr[0]` cleared for H, `addr[1:0]` cleared for W) and the access proceeds normally. `resp_fault` is never set for alignment.

## Test plan
- SW 0x100 with data 0xDEADBEEF, then LW 0x100:
  - store: `mem_write_enable=001` for exactly 1 cycle, `resp_valid` at E1;
  - load: `resp_rdata=0xDEADBEEF` at E2, `resp_fault=0`.
- After the previous test, load from the same word:
  - LB 0x103 → 0xFFFFFFDE;
  - LBU 0x103 → 0x000000DE;
  - LH 0x102 → 0xFFFFDEAD;
  - LHU 0x102 → 0x0000DEAD;
  - LB 0x100 → 0xFFFFFFEF.
- SB to 0xA0 with `req_wdata=0x1234565A` → `mem_write_enable=100` for 1 cycle, `mem_addr=0xA0`, `mem_data_in=0x0000005A`.
- LW 0x101 and SH 0x103:
  - with `LSU_MISALIGN_TRAP_EN`: `resp_fault=1` at E0, `mem_write_enable` stays 000;
  - without it: LW uses `mem_addr=0x100`, SH uses `mem_addr=0x102` with `mem_write_enable=010`.
- LW 0x1000 (`MEM_BYTES=4096`), funct3=011, and store with funct3=100 → each gives `resp_fault=1` and `resp_rdata=0`, with no RAM write.
- Assert `rst` during the CAPTURE state of a load → no `resp_valid`; state returns to IDLE; a new LW is accepted and completes normally.
